// File: rtl/normalize_pack_front_f64.sv
// Normalization front end for a binary64 round/pack stage.
// Takes an unnormalized sign/exponent/significand and shifts the significand left until bit 62 is
// the leading one. A value with bit 63 set is shifted right by one instead, and the lost bit is
// ORed into bit 0. The exponent is adjusted to match, and the result is registered for the
// pack stage.
// The leading-zero count is found in two steps:
//   * COUNT strips whole zero bytes, one byte per cycle, up to seven bytes.
//   * FINE counts the zeros left in the top byte and forms the result.
// Ports:
//   ap_clk, ap_rst             clock, asynchronous active-high reset
//   ap_start                   job request, sampled only while idle
//   zSign, zExp, zSig          operand (12-bit two's-complement biased exponent, 64-bit sig)
//   ap_done, ap_ready          one-cycle result-valid pulse (identical signals)
//   ap_idle                    idle with no request pending
//   out_sign, out_exp, out_sig registered normalized result, held until the next job
module normalize_pack_front_f64 (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  input  logic        zSign,
  input  logic [11:0] zExp,
  input  logic [63:0] zSig,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic        out_sign,
  output logic [11:0] out_exp,
  output logic [63:0] out_sig
);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StCount = 4'b0010,
    StFine  = 4'b0100,
    StDone  = 4'b1000
  } state_e;

  state_e      state_q;
  logic        sign_q;
  logic [11:0] exp_q;
  logic [63:0] sig_q;
  logic [6:0]  cnt_q;
  logic        out_sign_q;
  logic [11:0] out_exp_q;
  logic [63:0] out_sig_q;

  // Leading zeros of one byte; 8 when the byte is zero.
  function automatic logic [3:0] lzc8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = 4'(7 - i);
    end
    return n;
  endfunction

  logic [3:0]  fine;
  logic [6:0]  total;
  logic [11:0] norm_exp;
  logic [63:0] norm_sig;

  always_comb begin
    fine  = lzc8(sig_q[63:56]);
    total = cnt_q + 7'(fine);
    // The exponent drops by (total - 1) in every case, including total = 0 and total = 64.
    norm_exp = exp_q + 12'd1 - 12'(total);
    norm_sig = '0;
    if (total == 7'd0) begin
      // The top bit is already set: shift right by one and OR the lost bit into bit 0.
      norm_sig = {1'b0, sig_q[63:1]} | {63'd0, sig_q[0]};
    end else if (fine == 4'd8) begin
      // The significand is all zero.
      norm_sig = '0;
    end else if (fine == 4'd0) begin
      // Byte stripping went one bit too far. The bit shifted out is a zero that was shifted in.
      norm_sig = sig_q >> 1;
    end else begin
      norm_sig = sig_q << (fine - 4'd1);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sig_q      <= '0;
      cnt_q      <= '0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_sig_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            sign_q  <= zSign;
            exp_q   <= zExp;
            sig_q   <= zSig;
            cnt_q   <= '0;
            state_q <= StCount;
          end
        end
        StCount: begin
          if (sig_q[63:56] == 8'd0 && cnt_q < 7'd56) begin
            sig_q <= sig_q << 8;
            cnt_q <= cnt_q + 7'd8;
          end else begin
            state_q <= StFine;
          end
        end
        StFine: begin
          out_sign_q <= sign_q;
          out_exp_q  <= norm_exp;
          out_sig_q  <= norm_sig;
          state_q    <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ap_done  = (state_q == StDone);
  assign ap_ready = ap_done;
  assign ap_idle  = (state_q == StIdle) && !ap_start;
  assign out_sign = out_sign_q;
  assign out_exp  = out_exp_q;
  assign out_sig  = out_sig_q;

endmodule

// File: tb/tb_normalize_pack_front_f64.sv
// Directed bench for normalize_pack_front_f64. Expected values were worked out by hand.
module tb_normalize_pack_front_f64;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        zSign;
  logic [11:0] zExp;
  logic [63:0] zSig;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic        out_sign;
  logic [11:0] out_exp;
  logic [63:0] out_sig;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  normalize_pack_front_f64 dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .zSign    (zSign),
    .zExp     (zExp),
    .zSig     (zSig),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .out_sign (out_sign),
    .out_exp  (out_exp),
    .out_sig  (out_sig)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Cycle index. It is stable between rising edges.
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for ap_done, sampling on falling edges, for at most 20 cycles.
  task automatic wait_done(input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        found = 1'b1;
        break;
      end
    end
    check_eq({tag, " done seen"}, 64'(found), 64'd1);
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic sgn, input logic [11:0] e, input logic [63:0] s);
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " ready"}, 64'(ap_ready), 64'd1);
    check_eq({tag, " sign"}, 64'(out_sign), 64'(sgn));
    check_eq({tag, " exp"}, 64'(out_exp), 64'(e));
    check_eq({tag, " sig"}, out_sig, s);
  endtask

  task automatic run_job(input string tag, input logic sgn, input logic [11:0] e,
                         input logic [63:0] s, input int exp_lat,
                         input logic [11:0] oe, input logic [63:0] os);
    int t0;
    bit found;
    @(negedge ap_clk);
    zSign    = sgn;
    zExp     = e;
    zSig     = s;
    ap_start = 1'b1;
    t0       = cyc;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    // The DUT must not look at its inputs once the job has been accepted.
    zSign = ~sgn;
    zExp  = 12'($urandom);
    zSig  = {$urandom, $urandom};
    wait_done(tag, found);
    check_result(tag, cyc - t0, exp_lat, sgn, oe, os);
    @(negedge ap_clk);
    check_eq({tag, " pulse"}, 64'(ap_done), 64'd0);
    check_eq({tag, " hold"}, out_sig, os);
    check_eq({tag, " idle"}, 64'(ap_idle), 64'd1);
  endtask

  initial begin
    int t0;
    bit found;
    bit seen;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    zSign    = 1'b0;
    zExp     = '0;
    zSig     = '0;
    repeat (2) @(negedge ap_clk);
    check_eq("reset done", 64'(ap_done), 64'd0);
    check_eq("reset ready", 64'(ap_ready), 64'd0);
    check_eq("reset idle", 64'(ap_idle), 64'd1);
    check_eq("reset exp", 64'(out_exp), 64'd0);
    check_eq("reset sig", out_sig, 64'd0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // Directed vectors.
    run_job("lsb", 1'b0, 12'h400, 64'h0000_0000_0000_0001, 10, 12'h3C2, 64'h4000_0000_0000_0000);
    run_job("norm", 1'b0, 12'h3FF, 64'h4000_0000_0000_0000, 3, 12'h3FF, 64'h4000_0000_0000_0000);
    run_job("jam", 1'b1, 12'h3FF, 64'h8000_0000_0000_0003, 3, 12'h400, 64'h4000_0000_0000_0001);
    run_job("zero", 1'b0, 12'h010, 64'h0, 10, 12'hFD1, 64'h0);
    run_job("fine0", 1'b0, 12'h3FF, 64'h0080_0000_0000_0000, 4, 12'h3F8, 64'h4000_0000_0000_0000);
    run_job("byte7", 1'b1, 12'h3FF, 64'h0000_0000_0000_0080, 10, 12'h3C8, 64'h4000_0000_0000_0000);
    run_job("mixed", 1'b0, 12'h3FF, 64'h0000_1234_5678_9ABC, 5, 12'h3ED, 64'h48D1_59E2_6AF0_0000);
    run_job("mid", 1'b0, 12'h3FF, 64'h0000_0001_0000_0000, 6, 12'h3E1, 64'h4000_0000_0000_0000);
    run_job("wrapdn", 1'b0, 12'h000, 64'h0000_0000_0000_0001, 10, 12'hFC2, 64'h4000_0000_0000_0000);
    run_job("wrapup", 1'b0, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3, 12'h000, 64'h7FFF_FFFF_FFFF_FFFF);

    // A reset in the middle of a job aborts it and clears the outputs.
    @(negedge ap_clk);
    zSign    = 1'b1;
    zExp     = 12'h400;
    zSig     = 64'h1;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    repeat (2) @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check_eq("rst sig", out_sig, 64'd0);
    check_eq("rst exp", 64'(out_exp), 64'd0);
    check_eq("rst sign", 64'(out_sign), 64'd0);
    check_eq("rst idle", 64'(ap_idle), 64'd1);
    #1 ap_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1'b1;
    end
    check_eq("rst no done", 64'(seen), 64'd0);
    run_job("postrst", 1'b1, 12'h400, 64'h1, 10, 12'h3C2, 64'h4000_0000_0000_0000);

    // Start held high: the second job is accepted in the idle cycle right after the first DONE.
    @(negedge ap_clk);
    zSign    = 1'b0;
    zExp     = 12'h3FF;
    zSig     = 64'h00FF_0000_0000_0000;
    ap_start = 1'b1;
    t0       = cyc;
    @(posedge ap_clk);
    #1;
    zSign = 1'b1;
    zExp  = 12'h400;
    zSig  = 64'h1;
    wait_done("b2b1", found);
    check_result("b2b1", cyc - t0, 4, 1'b0, 12'h3F8, 64'h7F80_0000_0000_0000);
    @(negedge ap_clk);
    check_eq("b2b idle busy", 64'(ap_idle), 64'd0);
    wait_done("b2b2", found);
    ap_start = 1'b0;
    check_result("b2b2", cyc - t0, 15, 1'b1, 12'h3C2, 64'h4000_0000_0000_0000);
    repeat (3) @(negedge ap_clk);
    check_eq("b2b end idle", 64'(ap_idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
